// File: rtl/bsg_tag_serial_rx_if.sv
// bsg_tag_serial_rx_if: serial tag input and buffered payload handshake (parity_err_o with BSG_TAG_RX_PARITY_EN)
interface bsg_tag_serial_rx_if #(parameter int payload_width_p = 32);
  logic tdi_i;
  logic tms_i;
  logic yumi_i;
  logic v_o;
  logic [payload_width_p-1:0] data_o;
  logic node_reset_o;
  logic overflow_o;
  logic busy_o;
`ifdef BSG_TAG_RX_PARITY_EN
  logic parity_err_o;
  modport master (output tdi_i, tms_i, yumi_i, input v_o, data_o, node_reset_o, overflow_o, busy_o, parity_err_o);
  modport slave (input tdi_i, tms_i, yumi_i, output v_o, data_o, node_reset_o, overflow_o, busy_o, parity_err_o);
`else
  modport master (output tdi_i, tms_i, yumi_i, input v_o, data_o, node_reset_o, overflow_o, busy_o);
  modport slave (input tdi_i, tms_i, yumi_i, output v_o, data_o, node_reset_o, overflow_o, busy_o);
`endif
endinterface

// File: rtl/bsg_tag_serial_rx.sv
// bsg_tag_serial_rx: frames, filters and deserializes bsg_tag packets into a one-entry buffer (optional BSG_TAG_RX_PARITY_EN)
module bsg_tag_serial_rx #(
  parameter int node_id_p = 0,
  parameter int id_width_p = 4,
  parameter int len_width_p = 6,
  parameter int payload_width_p = 32
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_tag_serial_rx_if.slave rx
);
  localparam int cw_lp = id_width_p > len_width_p ? id_width_p : len_width_p;
  typedef enum logic [2:0] {
    IDLE, HDR_ID, HDR_DNR, HDR_LEN, PAYLOAD
`ifdef BSG_TAG_RX_PARITY_EN
    , PARITY
`endif
  } state_e;
`ifdef BSG_TAG_RX_PARITY_EN
  localparam state_e end_st = PARITY;
`else
  localparam state_e end_st = IDLE;
`endif
  state_e state;
  logic [cw_lp-1:0] cnt;
  logic [id_width_p-1:0] id_r, id_n;
  logic dnr_r;
  logic [len_width_p-1:0] len_r, len_n;
  logic [payload_width_p-1:0] shift_r, shift_n, pay, data_r;
  logic v_r, node_reset_r, overflow_r;
  logic last, done, hit, par_ok, accept, load;
`ifdef BSG_TAG_RX_PARITY_EN
  logic par_r, parity_err_r;
`endif
  // next-field values, end-of-field detection and completion decision
  always_comb begin
    id_n = {rx.tdi_i, id_r[id_width_p-1:1]};
    len_n = {rx.tdi_i, len_r[len_width_p-1:1]};
    shift_n = shift_r | (payload_width_p'(rx.tdi_i) << cnt);
    pay = state == PAYLOAD ? shift_n : shift_r;
    last = (state == HDR_ID && cnt == cw_lp'(id_width_p - 1))
        || (state == HDR_LEN && cnt == cw_lp'(len_width_p - 1))
        || (state == PAYLOAD && cnt == cw_lp'(len_r) - cw_lp'(1));
`ifdef BSG_TAG_RX_PARITY_EN
    done = !rx.tms_i && state == PARITY;
    par_ok = rx.tdi_i == par_r;
`else
    done = !rx.tms_i && ((state == HDR_LEN && last && len_n == '0) || (state == PAYLOAD && last));
    par_ok = 1'b1;
`endif
    hit = id_r == id_width_p'(node_id_p);
    accept = done && hit && par_ok;
    load = accept && dnr_r && (!v_r || rx.yumi_i);
  end
  // packet framing FSM with registered outputs and payload buffer
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      cnt <= '0;
      id_r <= '0;
      dnr_r <= 1'b0;
      len_r <= '0;
      shift_r <= '0;
      data_r <= '0;
      v_r <= 1'b0;
      node_reset_r <= 1'b0;
      overflow_r <= 1'b0;
`ifdef BSG_TAG_RX_PARITY_EN
      par_r <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      node_reset_r <= accept && !dnr_r;
      v_r <= load || (v_r && !rx.yumi_i);
      if (load) data_r <= pay;
      if (accept && dnr_r && v_r && !rx.yumi_i) overflow_r <= 1'b1;
`ifdef BSG_TAG_RX_PARITY_EN
      if (done && hit && !par_ok) parity_err_r <= 1'b1;
      if (state != IDLE) par_r <= par_r ^ rx.tdi_i;
`endif
      if (rx.tms_i) state <= IDLE;
      else begin
        case (state)
          IDLE: if (rx.tdi_i) begin
            state <= HDR_ID;
            cnt <= '0;
            id_r <= '0;
            len_r <= '0;
            shift_r <= '0;
`ifdef BSG_TAG_RX_PARITY_EN
            par_r <= 1'b0;
`endif
          end
          HDR_ID: begin
            id_r <= id_n;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) state <= HDR_DNR;
          end
          HDR_DNR: begin
            dnr_r <= rx.tdi_i;
            state <= HDR_LEN;
          end
          HDR_LEN: begin
            len_r <= len_n;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last && len_n == '0) state <= end_st;
            else if (last) state <= PAYLOAD;
          end
          PAYLOAD: begin
            shift_r <= shift_n;
            cnt <= cnt + 1'b1;
            if (last) state <= end_st;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign rx.v_o = v_r;
  assign rx.data_o = data_r;
  assign rx.node_reset_o = node_reset_r;
  assign rx.overflow_o = overflow_r;
  assign rx.busy_o = state != IDLE;
`ifdef BSG_TAG_RX_PARITY_EN
  assign rx.parity_err_o = parity_err_r;
`endif
endmodule

// File: tb/tb_bsg_tag_serial_rx.sv
// tb_bsg_tag_serial_rx: directed scoreboard bench for bsg_tag_serial_rx
module tb_bsg_tag_serial_rx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  bsg_tag_serial_rx_if #(.payload_width_p(32)) rx_if ();
  bsg_tag_serial_rx #(.node_id_p(0), .id_width_p(4), .len_width_p(6), .payload_width_p(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .rx(rx_if));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic bit_out(input logic b, input logic y = 1'b0, input logic t = 1'b0);
    rx_if.tdi_i = b;
    rx_if.yumi_i = y;
    rx_if.tms_i = t;
    @(posedge clk);
    #1;
    rx_if.tdi_i = 1'b0;
    rx_if.yumi_i = 1'b0;
    rx_if.tms_i = 1'b0;
  endtask

  function automatic logic [31:0] model(input logic [5:0] len, input logic [63:0] pl);
    logic [63:0] m;
    m = pl & ((64'd1 << len) - 64'd1);
    return m[31:0];
  endfunction

  task automatic send(input logic [3:0] id, input logic dnr, input logic [5:0] len, input logic [63:0] pl,
                      input logic y_last = 1'b0, input logic flip = 1'b0, input int stop_after = -1);
    logic q[$];
    q.push_back(1'b1);
    for (int i = 0; i < 4; i++) q.push_back(id[i]);
    q.push_back(dnr);
    for (int i = 0; i < 6; i++) q.push_back(len[i]);
    for (int i = 0; i < int'(len); i++) q.push_back(pl[i]);
`ifdef BSG_TAG_RX_PARITY_EN
    begin
      logic p;
      p = 1'b0;
      for (int i = 1; i < q.size(); i++) p ^= q[i];
      q.push_back(p);
    end
`endif
    for (int i = 0; i < q.size(); i++) begin
      if (i == stop_after) return;
      bit_out(q[i] ^ (flip && i == q.size() - 1), y_last && i == q.size() - 1);
    end
  endtask

  task automatic expect_data(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, ".v"}, {63'd0, rx_if.v_o}, 64'd1);
    check({tag, ".data"}, {32'd0, rx_if.data_o}, {32'd0, e});
  endtask

  task automatic consume(input string tag);
    bit_out(1'b0, 1'b1);
    check({tag, ".v_clr"}, {63'd0, rx_if.v_o}, 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bit_out(1'b0);
  endtask

  initial begin
    rx_if.tdi_i = 1'b0;
    rx_if.tms_i = 1'b0;
    rx_if.yumi_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.v", {63'd0, rx_if.v_o}, 64'd0);
    check("rst.data", {32'd0, rx_if.data_o}, 64'd0);
    check("rst.nr", {63'd0, rx_if.node_reset_o}, 64'd0);
    check("rst.ovf", {63'd0, rx_if.overflow_o}, 64'd0);
    check("rst.busy", {63'd0, rx_if.busy_o}, 64'd0);
    reset_n = 1'b1;
    repeat (2) bit_out(1'b0);
    check("idle.busy", {63'd0, rx_if.busy_o}, 64'd0);

    exp_q.push_back(model(6'd8, 64'hA5));
    send(4'd0, 1'b1, 6'd8, 64'hA5);
    expect_data("a5");
    check("a5.busy", {63'd0, rx_if.busy_o}, 64'd0);
    consume("a5");
    check("a5.hold", {32'd0, rx_if.data_o}, 64'hA5);

    send(4'd0, 1'b0, 6'd0, 64'd0);
    check("nr.pulse", {63'd0, rx_if.node_reset_o}, 64'd1);
    check("nr.v", {63'd0, rx_if.v_o}, 64'd0);
    bit_out(1'b0);
    check("nr.clr", {63'd0, rx_if.node_reset_o}, 64'd0);

    send(4'd3, 1'b1, 6'd40, 64'hDE_ADBE_EF12);
    check("foreign.v", {63'd0, rx_if.v_o}, 64'd0);
    exp_q.push_back(model(6'd1, 64'd1));
    send(4'd0, 1'b1, 6'd1, 64'd1);
    expect_data("after_foreign");
    consume("after_foreign");

    exp_q.push_back(model(6'd8, 64'h11));
    send(4'd0, 1'b1, 6'd8, 64'h11);
    send(4'd0, 1'b1, 6'd8, 64'h22);
    expect_data("ovf");
    check("ovf.flag", {63'd0, rx_if.overflow_o}, 64'd1);
    consume("ovf");
    do_reset();
    exp_q.push_back(model(6'd8, 64'h11));
    send(4'd0, 1'b1, 6'd8, 64'h11);
    expect_data("pre_yumi");
    exp_q.push_back(model(6'd8, 64'h22));
    send(4'd0, 1'b1, 6'd8, 64'h22, 1'b1);
    expect_data("ovf_yumi");
    check("ovf_yumi.flag", {63'd0, rx_if.overflow_o}, 64'd0);
    consume("ovf_yumi");

    send(4'd0, 1'b1, 6'd8, 64'hFF, 1'b0, 1'b0, 15);
    check("abort.busy_mid", {63'd0, rx_if.busy_o}, 64'd1);
    bit_out(1'b0, 1'b0, 1'b1);
    check("abort.busy", {63'd0, rx_if.busy_o}, 64'd0);
    check("abort.v", {63'd0, rx_if.v_o}, 64'd0);
    exp_q.push_back(model(6'd4, 64'h5));
    send(4'd0, 1'b1, 6'd4, 64'h5);
    expect_data("after_abort");
    check("after_abort.ovf", {63'd0, rx_if.overflow_o}, 64'd0);
    consume("after_abort");

    exp_q.push_back(model(6'd40, 64'hAB_CDEF_0123));
    send(4'd0, 1'b1, 6'd40, 64'hAB_CDEF_0123);
    expect_data("len40");
    consume("len40");
    exp_q.push_back(model(6'd0, 64'd0));
    send(4'd0, 1'b1, 6'd0, 64'd0);
    expect_data("len0");
    consume("len0");
    exp_q.push_back(model(6'd63, 64'hFFFF_FFFF_FFFF_FFFF));
    send(4'd0, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_data("len63");
    consume("len63");

`ifdef BSG_TAG_RX_PARITY_EN
    exp_q.push_back(model(6'd8, 64'h3C));
    send(4'd0, 1'b1, 6'd8, 64'h3C);
    expect_data("par_ok");
    check("par_ok.err", {63'd0, rx_if.parity_err_o}, 64'd0);
    consume("par_ok");
    send(4'd0, 1'b1, 6'd8, 64'h3C, 1'b0, 1'b1);
    check("par_bad.v", {63'd0, rx_if.v_o}, 64'd0);
    check("par_bad.err", {63'd0, rx_if.parity_err_o}, 64'd1);
    check("par_bad.nr", {63'd0, rx_if.node_reset_o}, 64'd0);
`endif

    exp_q.push_back(model(6'd8, 64'h77));
    send(4'd0, 1'b1, 6'd8, 64'h77);
    send(4'd0, 1'b1, 6'd8, 64'h66);
    expect_data("pre_areset");
    check("pre_areset.ovf", {63'd0, rx_if.overflow_o}, 64'd1);
    send(4'd0, 1'b1, 6'd8, 64'h3C, 1'b0, 1'b0, 14);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset.v", {63'd0, rx_if.v_o}, 64'd0);
    check("areset.data", {32'd0, rx_if.data_o}, 64'd0);
    check("areset.nr", {63'd0, rx_if.node_reset_o}, 64'd0);
    check("areset.ovf", {63'd0, rx_if.overflow_o}, 64'd0);
    check("areset.busy", {63'd0, rx_if.busy_o}, 64'd0);
`ifdef BSG_TAG_RX_PARITY_EN
    check("areset.perr", {63'd0, rx_if.parity_err_o}, 64'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bit_out(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_tag_serial_rx.md
Name: bsg_tag_serial_rx

Overview:
- ASIC-side receiver for the bsg_tag serial config stream that the gateway FPGA drives on TDI/TMS, clocked by tag TCK.
- Frames serial packets, filters them by node ID, and deserializes the payload.
- Presents each accepted payload to one client register through a one-entry valid/yumi buffer, or issues a node-reset pulse.

Parameters:
- node_id_p, 0: ID this receiver answers to.
- id_width_p, 4: width of the header node-ID field.
- len_width_p, 6: width of the header payload-length field.
- payload_width_p, 32: width of the output data register.

Ports:
- clk_i, input, 1: tag clock (TCK); all logic on its rising edge.
- reset_n_i, input, 1: asynchronous, active-low reset.
- tdi_i, input, 1: serial data, sampled every rising clk_i.
- tms_i, input, 1: abort/resync; 1 forces the FSM to IDLE.
- v_o, output, 1: payload buffer holds valid data.
- data_o, output, payload_width_p: buffered payload.
- yumi_i, input, 1: consumer takes data_o this cycle; legal only when v_o=1.
- node_reset_o, output, 1: one-cycle pulse on an accepted reset packet.
- overflow_o, output, 1: sticky; a packet was dropped because the buffer was full.
- busy_o, output, 1: FSM not in IDLE.

Behaviour:
- Reset values while reset_n_i=0: FSM IDLE, all counters 0, v_o=0, data_o=0, node_reset_o=0, overflow_o=0, busy_o=0. Assertion takes effect asynchronously; deassertion is synchronous to clk_i.
- Packet format, one bit per clk_i, fields LSB first:
  - start bit (1);
  - id (id_width_p bits);
  - dnr bit (1 = data packet, 0 = reset packet);
  - len (len_width_p bits);
  - payload (len bits).
- FSM states:
  - IDLE: tdi_i=1 -> HDR_ID; tdi_i=0 stays IDLE.
  - HDR_ID: id_width_p cycles -> HDR_DNR.
  - HDR_DNR: 1 cycle -> HDR_LEN.
  - HDR_LEN: len_width_p cycles. Then -> PAYLOAD if len>0, else -> IDLE (completion evaluated that cycle).
  - PAYLOAD: len cycles -> IDLE (completion evaluated on the last bit).
- tms_i=1 in any state: next state IDLE. The partial packet is discarded, with no v_o, node_reset_o or overflow_o effect. tms_i has priority over every other transition.
- Payload assembly:
  - Bit k lands in shift-register bit k for k < payload_width_p; bits k >= payload_width_p are consumed and discarded.
  - The shift register is cleared at start bit, so data bits above len-1 read 0.
- Completion (packet end, id==node_id_p):
  - dnr=0: node_reset_o pulses 1 on the next cycle. v_o/data_o are unaffected and the buffer is not checked.
  - dnr=1 with buffer empty, or buffer full with yumi_i=1 in the same cycle: data_o loads and v_o=1 on the next cycle (latency 1 after the last payload bit).
  - dnr=1 with buffer full and no yumi_i: packet dropped, overflow_o is set, data_o unchanged.
- Mismatched id: the full packet length is still consumed with no outputs; framing stays aligned.
- yumi_i=1 with no simultaneous load: v_o=0 next cycle; data_o holds its value.
- Counter widths: max(id_width_p, len_width_p) bits. len uses the full unsigned range, up to 2^len_width_p - 1.
- busy_o=1 for every cycle the state is not IDLE.

Optional Feature:
- Macro: BSG_TAG_RX_PARITY_EN.
- When defined:
  - One parity bit follows the payload; even parity covers id, dnr, len and payload bits (start bit excluded).
  - Added state PARITY (1 cycle); completion is evaluated there instead of at the last payload bit.
  - On mismatch: packet dropped (no v_o, no node_reset_o) and the added sticky output parity_err_o (1 bit, reset 0) is set.
- When undefined: no PARITY state, no parity_err_o port, and the packet format is as above.

Test Plan:
- Data packet: id=0, dnr=1, len=8, payload 0xA5 -> v_o=1 one cycle after the last bit, data_o=0x000000A5, busy_o=0 thereafter.
- Reset packet: id=0, dnr=0, len=0 -> node_reset_o high for exactly 1 cycle; v_o stays 0.
- Foreign id: id=3, len=40, followed immediately by own-id packet with payload 0x1 -> only the second packet is accepted, data_o=0x1, proving framing stays aligned.
- Overflow: two own packets, 0x11 then 0x22, with no yumi_i -> data_o=0x11 and overflow_o=1. Repeat with yumi_i=1 on the second completion cycle -> data_o=0x22, overflow_o=0.
- Abort: tms_i=1 mid-payload, then a clean packet 0x5 -> no output from the aborted packet; data_o=0x5. Also assert reset_n_i mid-packet -> all outputs go to 0 immediately.
- Parity (with BSG_TAG_RX_PARITY_EN): a correct packet is accepted; the same packet with its parity bit flipped gives v_o=0 and parity_err_o=1.
